// File: rtl/ram_scale_ctrl.sv
// Load/scale sequencer owning both ports of ram_bank: streams words into an address
// window (LOAD) or read-modify-writes each word times a factor (SCALE). RAM_SCALE_SAT_EN saturates the product.
module ram_scale_ctrl #(
  parameter int ADDR_BIT = 3,
  parameter int DATA_BIT = 16,
  parameter int MULT_BIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_BIT-1:0] base,
  input  logic [ADDR_BIT:0]   count,
  input  logic [MULT_BIT-1:0] mult,
  input  logic                in_valid,
  input  logic [DATA_BIT-1:0] in_data,
  output logic                in_ready,
  output logic                busy,
  output logic                done,
  output logic                ram_en,
  output logic                ram_we,
  output logic                ram_re,
  output logic [ADDR_BIT-1:0] ram_addr_w,
  output logic [DATA_BIT-1:0] ram_d_w,
  output logic [ADDR_BIT-1:0] ram_addr_r,
  input  logic [DATA_BIT-1:0] ram_d_r
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RD, S_WR, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_BIT-1:0] r_base;
  logic [ADDR_BIT:0]   r_count;
  logic [MULT_BIT-1:0] r_mult;
  logic [ADDR_BIT:0]   r_idx;

  logic [ADDR_BIT-1:0] w_addr;
  logic [ADDR_BIT:0]   w_idx_nxt;
  logic                w_last;
  logic [DATA_BIT-1:0] w_scaled;

  // Window address wraps naturally through truncation to ADDR_BIT.
  assign w_addr    = r_base + r_idx[ADDR_BIT-1:0];
  assign w_idx_nxt = r_idx + 1'b1;
  assign w_last    = (w_idx_nxt >= r_count);

`ifdef RAM_SCALE_SAT_EN
  logic [DATA_BIT+MULT_BIT-1:0] w_prod;
  assign w_prod   = {{MULT_BIT{1'b0}}, ram_d_r} * {{DATA_BIT{1'b0}}, r_mult};
  assign w_scaled = (|w_prod[DATA_BIT+MULT_BIT-1:DATA_BIT]) ? {DATA_BIT{1'b1}}
                                                            : w_prod[DATA_BIT-1:0];
`else
  // Low DATA_BIT bits of the full product equal the product taken at DATA_BIT width.
  assign w_scaled = ram_d_r * {{(DATA_BIT-MULT_BIT){1'b0}}, r_mult};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_count <= '0;
      r_mult  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_base  <= base;
          r_count <= count;
          r_mult  <= mult;
          r_idx   <= '0;
          if (count == '0) r_state <= S_DONE;
          else if (mode)   r_state <= S_RD;
          else             r_state <= S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          r_idx <= w_idx_nxt;
          if (w_last) r_state <= S_DONE;
        end
        S_RD: r_state <= S_WR;
        S_WR: begin
          r_idx   <= w_idx_nxt;
          r_state <= w_last ? S_DONE : S_RD;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; LOAD passes the stream straight through.
  always_comb begin
    in_ready   = 1'b0;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr_w = '0;
    ram_d_w    = '0;
    ram_addr_r = '0;
    case (r_state)
      S_LOAD: begin
        in_ready   = 1'b1;
        ram_en     = 1'b1;
        ram_we     = in_valid;
        ram_addr_w = w_addr;
        ram_d_w    = in_data;
      end
      S_RD: begin
        ram_en     = 1'b1;
        ram_re     = 1'b1;
        ram_addr_r = w_addr;
      end
      S_WR: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr_w = w_addr;
        ram_d_w    = w_scaled;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/ram_scale_ctrl.md
Name: ram_scale_ctrl

Overview:
- Sequencer that owns both ports of ram_bank and replaces the open-loop mux21/feedback arrangement.
- LOAD mode: streams external words into a RAM address window.
- SCALE mode: read-modify-write of each word in the window, multiplied by a programmable factor.
- Sits directly upstream of ram_bank's write port and downstream of its read port.

Parameters:
- ADDR_BIT, 3, RAM address width; MEM_HEIGHT = 2^ADDR_BIT.
- DATA_BIT, 16, RAM word width.
- MULT_BIT, 4, width of the scale factor.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe, sampled only in IDLE.
- mode  in  1  0 = LOAD, 1 = SCALE; sampled with start.
- base  in  ADDR_BIT  first address of the window; sampled with start.
- count  in  ADDR_BIT+1  number of words, 0..MEM_HEIGHT; sampled with start.
- mult  in  MULT_BIT  unsigned scale factor; sampled with start.
- in_valid  in  1  LOAD data valid.
- in_data  in  DATA_BIT  LOAD data.
- in_ready  out  1  LOAD data accepted when in_valid & in_ready.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- ram_en  out  1  to ram_bank en.
- ram_we  out  1  to ram_bank we.
- ram_re  out  1  to ram_bank re.
- ram_addr_w  out  ADDR_BIT  to ram_bank addr_w.
- ram_d_w  out  DATA_BIT  to ram_bank d_w.
- ram_addr_r  out  ADDR_BIT  to ram_bank addr_r.
- ram_d_r  in  DATA_BIT  from ram_bank d_r.

Behaviour:
- ram_bank contract: write on the rising edge when en & we. Read data is valid on ram_d_r one cycle after the edge that samples en & re & addr_r.
- Reset (async, rst_n=0):
  - State goes to IDLE; internal address and word counters clear.
  - in_ready=0, busy=0, done=0, ram_en=0, ram_we=0, ram_re=0, ram_addr_w=0, ram_addr_r=0, ram_d_w=0.
  - Reset mid-command aborts immediately. Words already written stay written; there is no rollback.
- FSM states: IDLE, LOAD, RD, WR, DONE.
  - IDLE: start=1 latches mode/base/count/mult, clears index i. Next state is DONE if count=0, else LOAD (mode=0) or RD (mode=1). start while busy is ignored.
  - LOAD:
    - in_ready=1, ram_en=1, ram_we = in_valid, ram_addr_w = base+i, ram_d_w = in_data (combinational).
    - On handshake: i++. After handshake number count, go to DONE.
    - in_valid low stalls the state indefinitely.
  - RD: ram_en=1, ram_re=1, ram_addr_r = base+i; then go to WR.
  - WR:
    - ram_en=1, ram_we=1, ram_addr_w = base+i, ram_d_w = f(ram_d_r*mult); i++.
    - Go to RD if i+1 < count, else DONE.
    - Throughput is 2 cycles per word.
  - DONE: done=1 for exactly one cycle; then IDLE.
- busy=1 in every state except IDLE, including the DONE cycle.
- Address arithmetic: base+i is truncated to ADDR_BIT, so it wraps modulo MEM_HEIGHT. count=MEM_HEIGHT covers the whole RAM exactly once.
- Arithmetic: ram_d_r*mult is computed at DATA_BIT+MULT_BIT bits, unsigned. Default f = truncate to the low DATA_BIT bits. mult=0 writes zeros; mult=1 rewrites unchanged data.
- Outputs not driven by a state default to 0. ram_re=0 in LOAD; ram_we=0 in RD.
- Latency, SCALE with N words: done is asserted in cycle 2N+1 after the start-sampling edge. LOAD with no stalls: done in cycle N+1.

Optional Feature:
- Macro: RAM_SCALE_SAT_EN.
- Defined: f saturates. If any product bit above DATA_BIT-1 is set, write {DATA_BIT{1'b1}}; otherwise write the low bits.
- Undefined: plain truncation. No saturation logic is synthesized.

Test Plan:
- LOAD base=2, count=3, data 3,5,7 with continuous in_valid -> we pulses at addrs 2,3,4; RAM[2..4]=3,5,7; done in cycle 4; busy high cycles 1..4.
- Then SCALE base=2, count=3, mult=2 -> RAM[2..4]=6,10,14; done in cycle 7; re/we alternate on addresses 2,2,3,3,4,4.
- Wrap: LOAD then SCALE with base=6, count=4, mult=3, data 1,2,3,4 -> addresses 6,7,0,1 hold 3,6,9,12; no other address touched.
- Overflow: RAM[0]=0x9000, SCALE count=1, mult=2 -> RAM[0]=0x2000 without RAM_SCALE_SAT_EN, 0xFFFF with it.
- count=0 with start -> no ram_we/ram_re; done in cycle 1. Also: start pulsed while busy -> ignored, running command unchanged.
- LOAD with in_valid stalled 5 cycles mid-stream, then rst_n=0 during SCALE WR of word 2 -> all outputs 0 asynchronously, FSM in IDLE; word 1 keeps its scaled value, remaining words unchanged.
